// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit counters, write-first bypass and invalidation sweep
// Optional lookup/hit statistics counters are built when BTB_STATS_EN is defined.
module branch_target_buffer #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LookupValid,
    input  logic [ADDR_W-1:0] PcIn,
    output logic              PcMatchValid,
    output logic              JumpTaken,
    output logic [1:0]        CtrlState,
    output logic [ADDR_W-1:0] PredTarget,
    input  logic              UpdWriteEnable,
    input  logic [ADDR_W-1:0] UpdPc,
    input  logic [ADDR_W-1:0] UpdTarget,
    input  logic [1:0]        UpdCtrl,
    input  logic              InvalAll,
    output logic              Busy,
    output logic [15:0]       HitCount,
    output logic [15:0]       LookupCount
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         ctrl_q   [ENTRIES];
    logic [1:0]         ctrl_d   [ENTRIES];

    logic               match_q, match_d;
    logic               taken_q, taken_d;
    logic [1:0]         cstate_q, cstate_d;
    logic [ADDR_W-1:0]  pred_q, pred_d;

    logic [IDX_W-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               upd_fire, lk_active, lk_hit, raw_hit;
    logic [ADDR_W-1:0]  raw_tgt;
    logic [1:0]         raw_ctrl;
    logic               unused_pc_lsbs;

    assign lk_idx = PcIn[IDX_W+1:2];
    assign lk_tag = PcIn[ADDR_W-1:IDX_W+2];
    assign up_idx = UpdPc[IDX_W+1:2];
    assign up_tag = UpdPc[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{PcIn[1:0], UpdPc[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctrl_d    = ctrl_q;
        upd_fire  = (state_q == IDLE) && UpdWriteEnable && !InvalAll;
        lk_active = (state_q == IDLE) && LookupValid;

        case (state_q)
            IDLE: begin
                if (InvalAll) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                valid_d[cnt_q] = 1'b0;
                ctrl_d[cnt_q]  = 2'b01;
                if (InvalAll) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (upd_fire) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = UpdTarget;
            ctrl_d[up_idx]   = UpdCtrl;
        end

        // Write-first: a same-index update this edge is what the lookup sees.
        if (upd_fire && (up_idx == lk_idx)) begin
            raw_hit  = (up_tag == lk_tag);
            raw_tgt  = UpdTarget;
            raw_ctrl = UpdCtrl;
        end else begin
            raw_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
            raw_tgt  = target_q[lk_idx];
            raw_ctrl = ctrl_q[lk_idx];
        end

        lk_hit   = lk_active && raw_hit;
        match_d  = lk_hit;
        taken_d  = lk_hit && raw_ctrl[1];
        cstate_d = lk_hit ? raw_ctrl : 2'b00;
        pred_d   = lk_hit ? raw_tgt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= '0;
            match_q  <= 1'b0;
            taken_q  <= 1'b0;
            cstate_q <= 2'b00;
            pred_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            taken_q  <= taken_d;
            cstate_q <= cstate_d;
            pred_q   <= pred_d;
        end
    end

    // Payload arrays carry no reset; valid_q alone decides whether they matter.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctrl_q   <= ctrl_d;
    end

    assign PcMatchValid = match_q;
    assign JumpTaken    = taken_q;
    assign CtrlState    = cstate_q;
    assign PredTarget   = pred_q;
    assign Busy         = (state_q == SWEEP);

`ifdef BTB_STATS_EN
    logic [15:0] hits_q, hits_d;
    logic [15:0] looks_q, looks_d;

    always_comb begin
        hits_d  = hits_q;
        looks_d = looks_q;
        if (lk_active && (looks_q != 16'hFFFF)) begin
            looks_d = looks_q + 16'd1;
        end
        if (lk_hit && (hits_q != 16'hFFFF)) begin
            hits_d = hits_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q  <= 16'h0000;
            looks_q <= 16'h0000;
        end else begin
            hits_q  <= hits_d;
            looks_q <= looks_d;
        end
    end

    assign HitCount    = hits_q;
    assign LookupCount = looks_q;
`else
    assign HitCount    = 16'h0000;
    assign LookupCount = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer against a behavioural model
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        lv;
    logic [31:0] pc_in;
    logic        match, taken;
    logic [1:0]  cstate;
    logic [31:0] pred;
    logic        we;
    logic [31:0] upc, utgt;
    logic [1:0]  uctrl;
    logic        inval;
    logic        busy;
    logic [15:0] hitcnt, lkcnt;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk(clk), .rst(rst), .LookupValid(lv), .PcIn(pc_in),
        .PcMatchValid(match), .JumpTaken(taken), .CtrlState(cstate), .PredTarget(pred),
        .UpdWriteEnable(we), .UpdPc(upc), .UpdTarget(utgt), .UpdCtrl(uctrl),
        .InvalAll(inval), .Busy(busy), .HitCount(hitcnt), .LookupCount(lkcnt)
    );

    // Reference state: an entry remembers the full PC that wrote it.
    bit          m_valid [16];
    logic [31:0] m_pc    [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_ctrl  [16];
    bit          m_sweep;
    int          m_pos;
    int          m_hits, m_looks;

    logic [68:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic step(input bit r, input bit l, input logic [31:0] p,
                        input bit w, input logic [31:0] wp, input logic [31:0] wt,
                        input logic [1:0] wc, input bit inv);
        bit          hit;
        bit          idle;
        int          i;
        logic [31:0] e_tgt;
        logic [1:0]  e_ctrl;
        logic [15:0] e_hits, e_looks;
        @(negedge clk);
        rst = r; lv = l; pc_in = p; we = w; upc = wp; utgt = wt; uctrl = wc; inval = inv;
        hit = 0; e_tgt = 0; e_ctrl = 0;
        if (r) begin
            foreach (m_valid[k]) m_valid[k] = 0;
            m_sweep = 0; m_pos = 0; m_hits = 0; m_looks = 0;
        end else begin
            idle = !m_sweep;
            if (idle && w && !inv) begin
                i = int'(wp[5:2]);
                m_valid[i] = 1; m_pc[i] = wp; m_tgt[i] = wt; m_ctrl[i] = wc;
            end
            if (idle && l) begin
                i = int'(p[5:2]);
                hit = m_valid[i] && (m_pc[i][31:6] == p[31:6]);
                if (m_looks < 65535) m_looks++;
                if (hit && m_hits < 65535) m_hits++;
                if (hit) begin
                    e_tgt = m_tgt[i]; e_ctrl = m_ctrl[i];
                end
            end
            if (m_sweep) begin
                m_valid[m_pos] = 0; m_ctrl[m_pos] = 2'b01;
                if (inv) m_pos = 0;
                else if (m_pos == 15) m_sweep = 0;
                else m_pos++;
            end else if (inv) begin
                m_sweep = 1; m_pos = 0;
            end
        end
`ifdef BTB_STATS_EN
        e_hits = 16'(m_hits); e_looks = 16'(m_looks);
`else
        e_hits = 16'h0; e_looks = 16'h0;
`endif
        exp_q.push_back({hit, hit & e_ctrl[1], e_ctrl, e_tgt, m_sweep, e_hits, e_looks});
    endtask

    task automatic idle_cyc();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic lookup(input logic [31:0] p);
        step(0, 1, p, 0, 0, 0, 0, 0);
    endtask
    task automatic update(input logic [31:0] p, input logic [31:0] t, input logic [1:0] c);
        step(0, 0, 0, 1, p, t, c, 0);
    endtask

    always @(posedge clk) begin
        logic [68:0] e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {match, taken, cstate, pred, busy, hitcnt, lkcnt};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL btb_out t=%0t: got match=%b taken=%b ctrl=%b tgt=%h busy=%b hits=%0d looks=%0d, expected match=%b taken=%b ctrl=%b tgt=%h busy=%b hits=%0d looks=%0d",
                         $time, a[68], a[67], a[66:65], a[64:33], a[32], a[31:16], a[15:0],
                         e[68], e[67], e[66:65], e[64:33], e[32], e[31:16], e[15:0]);
            end
        end
    end

    initial begin
        int w;
        rst = 1; lv = 0; pc_in = 0; we = 0; upc = 0; utgt = 0; uctrl = 0; inval = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Cold miss, then a strongly-taken entry.
        lookup(32'h40);
        update(32'h40, 32'h100, 2'b11);
        lookup(32'h40);
        // Alias on index 0, then same-cycle update/lookup bypass.
        lookup(32'h80);
        step(0, 1, 32'h40, 1, 32'h40, 32'h100, 2'b01, 0);
        lookup(32'h40);
        // Fill all entries, sweep with a dropped update mid-way, confirm misses.
        for (int i = 0; i < 16; i++) update(32'h1000 | (i << 2), 32'h2000 + i, 2'(i));
        for (int i = 0; i < 16; i++) lookup(32'h1000 | (i << 2));
        step(0, 0, 0, 1, 32'h1004, 32'hBAD, 2'b11, 1);
        for (int i = 0; i < 18; i++) begin
            if (i == 3) step(0, 1, 32'h1008, 1, 32'h1008, 32'hBAD, 2'b10, 0);
            else lookup(32'h1000 | ((i % 16) << 2));
        end
        for (int i = 0; i < 16; i++) lookup(32'h1000 | (i << 2));
        // Reset in the middle of a sweep.
        for (int i = 0; i < 4; i++) update(32'h40 | (i << 2), 32'h300 + i, 2'b10);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) idle_cyc();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) lookup(32'h40 | (i << 2));
        update(32'h44, 32'h444, 2'b11);
        lookup(32'h44);
        // Randomised traffic over a small PC pool so aliasing and hits are common.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p, wp;
            p  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            wp = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) p = $urandom;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, p,
                 $urandom_range(0, 2) == 0, wp, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 79) == 0);
        end
        idle_cyc();
        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
